// File: rtl/spi_sclk_burst_gen.sv
// SPI SCLK burst generator: N periods of 2*H clkIn cycles per start, CPOL/CPHA latched per transfer.
// All outputs registered, first SCLK edge H+1 cycles after start; starts ignored while busy, abort wins.
module spi_sclk_burst_gen #(
  parameter int DIV_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clkIn,
  input  logic                 rstNIn,
  input  logic                 startIn,
  input  logic [DIV_WIDTH-1:0] halfPeriodIn,
  input  logic [CNT_WIDTH-1:0] numCyclesIn,
  input  logic                 cpolIn,
  input  logic                 cphaIn,
  input  logic                 abortIn,
  output logic                 busyOut,
  output logic                 doneOut,
  output logic                 errOut,
  output logic                 spiClkOut,
  output logic                 risingEdgeOut,
  output logic                 fallingEdgeOut,
  output logic                 shiftStrobeOut,
  output logic                 sampleStrobeOut,
  output logic [CNT_WIDTH-1:0] cycleCountOut
);

  typedef enum logic [1:0] {IDLE, LEAD, ACTIVE, TRAIL} state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t state, stateNext;

  logic [DIV_WIDTH-1:0] halfReg, halfRegNext;
  logic [DIV_WIDTH-1:0] halfCnt, halfCntNext;
  logic [CNT_WIDTH-1:0] numReg, numRegNext;
  logic [CNT_WIDTH-1:0] countNext;
  logic                 cpolReg, cpolRegNext;
  logic                 cphaReg, cphaRegNext;
  logic                 trailHalf, trailNext;

  logic busyNext, doneNext, errNext, spiClkNext;
  logic riseNext, fallNext, shiftNext, sampleNext;

  logic startOk, startBad, halfDone, lastPeriod, abortNow, leadEdge, trailEdge;

  always_comb begin
    startOk    = startIn && (halfPeriodIn != '0) && (numCyclesIn != '0);
    startBad   = startIn && !startOk;
    halfDone   = (halfCnt == halfReg - DIV_ONE);
    lastPeriod = (cycleCountOut == numReg - CNT_ONE);
    abortNow   = abortIn && (state != IDLE);
    leadEdge   = halfDone && ((state == LEAD) || ((state == ACTIVE) && trailHalf));
    trailEdge  = halfDone && (state == ACTIVE) && !trailHalf;
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (startOk)                 stateNext = LEAD;
      LEAD:    if (halfDone)                stateNext = ACTIVE;
      ACTIVE:  if (trailEdge && lastPeriod) stateNext = TRAIL;
      TRAIL:   if (halfDone)                stateNext = IDLE;
      default:                              stateNext = IDLE;
    endcase
    if (abortNow) begin
      stateNext = IDLE;
    end
  end

  always_comb begin
    halfRegNext = halfReg;
    numRegNext  = numReg;
    cpolRegNext = cpolReg;
    cphaRegNext = cphaReg;
    countNext   = cycleCountOut;
    trailNext   = trailHalf;
    halfCntNext = halfDone ? '0 : halfCnt + DIV_ONE;
    spiClkNext  = spiClkOut;
    shiftNext   = 1'b0;
    sampleNext  = 1'b0;
    doneNext    = 1'b0;
    errNext     = 1'b0;

    if (state == IDLE) begin
      spiClkNext  = cpolIn;
      halfCntNext = '0;
      trailNext   = 1'b0;
      errNext     = startBad;
      if (startOk) begin
        halfRegNext = halfPeriodIn;
        numRegNext  = numCyclesIn;
        cpolRegNext = cpolIn;
        cphaRegNext = cphaIn;
        countNext   = '0;
        // CPHA=0 slaves sample on the first edge, so the first bit goes out now.
        shiftNext   = !cphaIn;
      end
    end

    if (leadEdge) begin
      spiClkNext = !cpolReg;
      trailNext  = 1'b0;
      shiftNext  = cphaReg;
      sampleNext = !cphaReg;
    end

    if (trailEdge) begin
      spiClkNext = cpolReg;
      trailNext  = 1'b1;
      countNext  = cycleCountOut + CNT_ONE;
      shiftNext  = !cphaReg && !lastPeriod;
      sampleNext = cphaReg;
    end

    if ((state == TRAIL) && halfDone) begin
      doneNext = 1'b1;
    end

    if (abortNow) begin
      spiClkNext  = cpolReg;
      shiftNext   = 1'b0;
      sampleNext  = 1'b0;
      doneNext    = 1'b0;
      countNext   = cycleCountOut;
      halfCntNext = '0;
      trailNext   = 1'b0;
    end

    busyNext = (stateNext != IDLE);
    riseNext = spiClkNext && !spiClkOut && !abortNow;
    fallNext = !spiClkNext && spiClkOut && !abortNow;
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      halfReg         <= '0;
      numReg          <= '0;
      cpolReg         <= 1'b0;
      cphaReg         <= 1'b0;
      halfCnt         <= '0;
      trailHalf       <= 1'b0;
      cycleCountOut   <= '0;
      busyOut         <= 1'b0;
      doneOut         <= 1'b0;
      errOut          <= 1'b0;
      spiClkOut       <= 1'b0;
      risingEdgeOut   <= 1'b0;
      fallingEdgeOut  <= 1'b0;
      shiftStrobeOut  <= 1'b0;
      sampleStrobeOut <= 1'b0;
    end else begin
      halfReg         <= halfRegNext;
      numReg          <= numRegNext;
      cpolReg         <= cpolRegNext;
      cphaReg         <= cphaRegNext;
      halfCnt         <= halfCntNext;
      trailHalf       <= trailNext;
      cycleCountOut   <= countNext;
      busyOut         <= busyNext;
      doneOut         <= doneNext;
      errOut          <= errNext;
      spiClkOut       <= spiClkNext;
      risingEdgeOut   <= riseNext;
      fallingEdgeOut  <= fallNext;
      shiftStrobeOut  <= shiftNext;
      sampleStrobeOut <= sampleNext;
    end
  end

endmodule
